// File: rtl/sel_gen_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sel_gen_pkg
// Description : Shared state and scan-direction encodings for sel_gen.
// Revision    : 1.0
// ============================================================================
package sel_gen_pkg;

    localparam logic [0:0] ST_MANUAL = 1'b0;
    localparam logic [0:0] ST_AUTO   = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Two-bit modular step of the select code in the given direction.
    function automatic logic [1:0] sel_step(input logic [1:0] s, input logic d);
        return (d == DIR_DOWN) ? (s - 2'd1) : (s + 2'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Active-low key synchroniser, debouncer and press pulse.
// Revision    : 1.0
// ============================================================================
module key_debounce
    import sel_gen_pkg::*;
#(
    parameter int DB_CYCLES = 240000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int              CW         = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]   c_cnt_last = CW'(DB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_stable_d;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // The pulse is taken from the delayed stable level so it stays registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
            r_cnt      <= '0;
            r_press    <= 1'b0;
        end else begin
            r_sync1    <= key_n;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            r_press    <= r_stable_d & ~r_stable;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/sel_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sel_gen
// Description : Manual/auto 2-bit select generator driving the LED decoder.
// Revision    : 1.0
// ============================================================================
module sel_gen
    import sel_gen_pkg::*;
#(
    parameter int DB_CYCLES   = 240000,
    parameter int STEP_CYCLES = 6000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_step,
    input  logic       key_mode,
    output logic [1:0] sel,
    output logic       sel_upd,
    output logic       auto_mode,
    output logic       dir
);

    localparam int            TW          = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TW-1:0] c_tick_last = TW'(STEP_CYCLES - 1);

    logic          w_step_press;
    logic          w_mode_press;
    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic [1:0]    r_sel;
    logic [1:0]    w_sel_nxt;
    logic          r_sel_upd;
    logic          w_sel_upd_nxt;
    logic          r_dir;
    logic          w_dir_nxt;
    logic          w_tick;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_step (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_step),
        .press (w_step_press)
    );

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_mode (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_mode),
        .press (w_mode_press)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_MANUAL;
            r_timer   <= '0;
            r_sel     <= 2'd0;
            r_sel_upd <= 1'b0;
            r_dir     <= DIR_UP;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_sel     <= w_sel_nxt;
            r_sel_upd <= w_sel_upd_nxt;
            r_dir     <= w_dir_nxt;
        end
    end

    // A mode press pre-empts both the step key and any coincident timer tick.
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_sel_nxt     = r_sel;
        w_sel_upd_nxt = 1'b0;
        w_dir_nxt     = r_dir;
        w_tick        = (r_timer == c_tick_last);
        if (w_mode_press) begin
            w_state_nxt = (r_state == ST_AUTO) ? ST_MANUAL : ST_AUTO;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                ST_MANUAL: begin
                    if (w_step_press) begin
                        w_sel_nxt     = sel_step(r_sel, DIR_UP);
                        w_sel_upd_nxt = 1'b1;
                    end
                end
                ST_AUTO: begin
                    w_timer_nxt = w_tick ? '0 : (r_timer + TW'(1));
                    if (w_tick) begin
                        w_sel_nxt     = sel_step(r_sel, r_dir);
                        w_sel_upd_nxt = 1'b1;
                    end
                    if (w_step_press) begin
                        w_dir_nxt = ~r_dir;
                    end
                end
            endcase
        end
    end

    assign sel       = r_sel;
    assign sel_upd   = r_sel_upd;
    assign auto_mode = (r_state == ST_AUTO);
    assign dir       = r_dir;

endmodule
`default_nettype wire

// File: tb/tb_sel_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sel_gen
// Description : Self-checking bench for sel_gen with a sliding-window model.
// Revision    : 1.0
// ============================================================================
module tb_sel_gen;

    localparam int DB   = 4;
    localparam int STEP = 10;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       key_step = 1'b1;
    logic       key_mode = 1'b1;
    logic [1:0] sel;
    logic       sel_upd;
    logic       auto_mode;
    logic       dir;

    sel_gen #(.DB_CYCLES(DB), .STEP_CYCLES(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_step  (key_step),
        .key_mode  (key_mode),
        .sel       (sel),
        .sel_upd   (sel_upd),
        .auto_mode (auto_mode),
        .dir       (dir)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a key level is accepted once the last DB synchronised
    // samples all disagree with the accepted level; its effect lands 2 edges later.
    bit [DB+1:0] hs = '1;
    bit [DB+1:0] hm = '1;
    bit          st_s = 1'b1;
    bit          st_m = 1'b1;
    bit [1:0]    ps = '0;
    bit [1:0]    pm = '0;
    logic [1:0]  m_sel = 2'd0;
    bit          m_upd = 1'b0;
    bit          m_auto = 1'b0;
    bit          m_dir = 1'b0;
    int          n = 0;
    int          entry = 0;
    bit          es, em, acc_s, acc_m;

    function automatic bit window_differs(input bit [DB+1:0] h, input bit st);
        for (int k = 2; k <= DB + 1; k++)
            if (h[k] == st) return 1'b0;
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            hs = '1; hm = '1; st_s = 1'b1; st_m = 1'b1; ps = '0; pm = '0;
            m_sel = 2'd0; m_upd = 1'b0; m_auto = 1'b0; m_dir = 1'b0;
            n = 0; entry = 0;
        end else begin
            n++;
            hs = {hs[DB:0], key_step};
            hm = {hm[DB:0], key_mode};
            acc_s = 1'b0; acc_m = 1'b0;
            if (window_differs(hs, st_s)) begin st_s = ~st_s; acc_s = (st_s == 1'b0); end
            if (window_differs(hm, st_m)) begin st_m = ~st_m; acc_m = (st_m == 1'b0); end
            es = ps[1]; em = pm[1];
            ps = {ps[0], acc_s};
            pm = {pm[0], acc_m};
            m_upd = 1'b0;
            if (em) begin
                m_auto = ~m_auto;
                if (m_auto) entry = n;
            end else if (!m_auto) begin
                if (es) begin m_sel = m_sel + 2'd1; m_upd = 1'b1; end
            end else begin
                if (((n - entry) % STEP) == 0) begin
                    m_sel = m_dir ? (m_sel + 2'd3) : (m_sel + 2'd1);
                    m_upd = 1'b1;
                end
                if (es) m_dir = ~m_dir;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en && !rst) begin
            check("model_sel", sel, m_sel);
            check("model_sel_upd", sel_upd, m_upd);
            check("model_auto", auto_mode, m_auto);
            check("model_dir", dir, m_dir);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic press(input bit on_step, input bit on_mode, input int low, input int high,
                         output int upd_cnt, output int upd_edge);
        upd_cnt  = 0;
        upd_edge = 0;
        @(negedge clk);
        key_step = on_step ? 1'b0 : 1'b1;
        key_mode = on_mode ? 1'b0 : 1'b1;
        for (int i = 1; i <= low + high; i++) begin
            @(negedge clk);
            if (sel_upd) begin
                upd_cnt++;
                if (upd_edge == 0) upd_edge = i;
            end
            if (i == low) begin key_step = 1'b1; key_mode = 1'b1; end
        end
    endtask

    task automatic wait_upd(input int budget, output logic [1:0] v, output bit ok);
        ok = 1'b0;
        v  = 2'd0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (sel_upd) begin v = sel; ok = 1'b1; end
        end
    endtask

    typedef struct {
        int         low;
        int         high;
        logic [1:0] exp_sel;
        int         exp_upd;
        int         exp_edge;
    } vec_t;

    vec_t       vecs [8];
    logic [1:0] auto_up [3];
    int         uc, ue, cnt, hold_s, hold_m;
    logic [1:0] v;
    bit         ok;

    initial begin
        vecs[0] = '{8, 8, 2'd1, 1, 8};
        vecs[1] = '{8, 8, 2'd2, 1, 8};
        vecs[2] = '{8, 8, 2'd3, 1, 8};
        vecs[3] = '{8, 8, 2'd0, 1, 8};
        vecs[4] = '{8, 8, 2'd1, 1, 8};
        vecs[5] = '{3, 8, 2'd1, 0, 0};
        vecs[6] = '{4, 8, 2'd2, 1, 8};
        vecs[7] = '{1, 6, 2'd2, 0, 0};
        auto_up[0] = 2'd2; auto_up[1] = 2'd3; auto_up[2] = 2'd0;

        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        check("reset_sel", sel, 0);
        check("reset_auto", auto_mode, 0);
        check("reset_dir", dir, 0);

        // Manual-mode presses, glitches and minimum-hold boundary.
        for (int t = 0; t < 8; t++) begin
            press(1'b1, 1'b0, vecs[t].low, vecs[t].high, uc, ue);
            check($sformatf("vec%0d_sel", t), sel, vecs[t].exp_sel);
            check($sformatf("vec%0d_upd_cnt", t), uc, vecs[t].exp_upd);
            check($sformatf("vec%0d_upd_edge", t), ue, vecs[t].exp_edge);
        end

        // Bouncing key followed by a solid press: one increment only.
        cnt = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (sel_upd) cnt++;
            if (i < 20)      key_step = ((i % 4) < 2) ? 1'b0 : 1'b1;
            else if (i < 28) key_step = 1'b0;
            else             key_step = 1'b1;
        end
        check("bounce_upd_cnt", cnt, 1);
        check("bounce_sel", sel, 3);
        press(1'b1, 1'b0, 8, 8, uc, ue);
        check("wrap_sel", sel, 0);
        press(1'b1, 1'b0, 8, 8, uc, ue);
        check("pre_auto_sel", sel, 1);

        // Auto mode: steps up every STEP cycles, step key reverses direction.
        press(1'b0, 1'b1, 8, 8, uc, ue);
        check("auto_entered", auto_mode, 1);
        check("auto_no_early_step", uc, 0);
        for (int k = 0; k < 3; k++) begin
            wait_upd(STEP + 2, v, ok);
            check($sformatf("auto_up_timeout%0d", k), ok, 1);
            check($sformatf("auto_up_sel%0d", k), v, auto_up[k]);
        end
        press(1'b1, 1'b0, 4, 1, uc, ue);
        repeat (3) @(negedge clk);
        check("auto_dir_toggled", dir, 1);
        check("auto_sel_unchanged", sel, 0);
        wait_upd(STEP + 2, v, ok);
        check("auto_down_timeout0", ok, 1);
        check("auto_down_sel0", v, 3);
        wait_upd(STEP + 2, v, ok);
        check("auto_down_timeout1", ok, 1);
        check("auto_down_sel1", v, 2);

        // Asynchronous reset five cycles into the step timer.
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_sel", sel, 0);
        check("async_rst_upd", sel_upd, 0);
        check("async_rst_auto", auto_mode, 0);
        check("async_rst_dir", dir, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (sel_upd) cnt++;
        end
        check("post_rst_no_step", cnt, 0);
        check("post_rst_manual", auto_mode, 0);

        // Simultaneous mode and step press: mode wins, step discarded.
        press(1'b1, 1'b0, 8, 8, uc, ue);
        press(1'b1, 1'b0, 8, 8, uc, ue);
        check("sim_pre_sel", sel, 2);
        press(1'b1, 1'b1, 8, 8, uc, ue);
        check("sim_upd_cnt", uc, 0);
        check("sim_auto", auto_mode, 1);
        check("sim_sel", sel, 2);
        check("sim_dir", dir, 0);
        press(1'b0, 1'b1, 8, 8, uc, ue);
        check("leave_auto", auto_mode, 0);
        check("leave_sel_model", sel, m_sel);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (sel_upd) cnt++;
        end
        check("manual_hold_no_upd", cnt, 0);

        // Randomised key activity against the model.
        hold_s = 1;
        hold_m = 1;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            hold_s = hold_s - 1;
            hold_m = hold_m - 1;
            if (hold_s == 0) begin key_step = ~key_step; hold_s = $urandom_range(1, 10); end
            if (hold_m == 0) begin key_mode = ~key_mode; hold_m = $urandom_range(4, 40); end
        end
        key_step = 1'b1;
        key_mode = 1'b1;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
